code_conv_arbiter: RTL and testbench

Shared Gray/binary code-conversion engine with a round-robin arbiter in front of it. Up to NREQ requesters each submit a WIDTH-bit word plus a direction bit (binary→Gray or Gray→binary). The block grants one requester at a time, performs the conversion in a registered stage, and returns the result with the requester ID over a valid/ready response channel. It replaces per-client converter instances wherever several agents need occasional code conversion.

---
 rtl/code_conv_arbiter.sv | 160 ++++++++++++++++
 tb/tb_code_conv_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/code_conv_arbiter.sv
// Round-robin arbitrated, shared Gray<->binary conversion engine.
// One request is accepted in IDLE. It is converted in CONV and returned in RESP over valid/ready.
module code_conv_arbiter #(
  parameter  int unsigned WIDTH = 4,
  parameter  int unsigned NREQ  = 4,
  parameter  int unsigned CNTW  = 8,
  localparam int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_mode,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_mode,
  output logic                  busy,
  output logic [CNTW-1:0]       done_cnt
);

  typedef enum logic [1:0] {IDLE, CONV, RESP} state_e;

  state_e            state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]  lat_data_q, lat_data_d;
  logic              lat_mode_q, lat_mode_d;
  logic [IDW-1:0]    lat_id_q, lat_id_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic              rsp_mode_q, rsp_mode_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;
  logic [CNTW-1:0]   done_cnt_q, done_cnt_d;

  logic [WIDTH-1:0]  req_word [NREQ];
  logic              grant_found;
  logic [IDW-1:0]    grant_id;
  logic [IDW-1:0]    scan_idx;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b            = '0;
    b[WIDTH-1]   = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Unpack the flat request data bus into per-requester words
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign req_word[gi] = req_data[gi*WIDTH +: WIDTH];
  end

  // Round-robin search: the first valid requester at or after rr_ptr wins (the index wraps mod NREQ)
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = rr_ptr_q + IDW'(k);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  // Next-state and grant logic
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lat_data_d  = lat_data_q;
    lat_mode_d  = lat_mode_q;
    lat_id_d    = lat_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_mode_d  = rsp_mode_q;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;
    done_cnt_d  = done_cnt_q;
    req_ready   = '0;

    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_id] = 1'b1;
          lat_data_d          = req_word[grant_id];
          lat_mode_d          = req_mode[grant_id];
          lat_id_d            = grant_id;
          busy_d              = 1'b1;
          state_d             = CONV;
        end
      end
      CONV: begin
        rsp_data_d  = lat_mode_q ? gray2bin(lat_data_q) : bin2gray(lat_data_q);
        rsp_id_d    = lat_id_q;
        rsp_mode_d  = lat_mode_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          rr_ptr_d    = lat_id_q + IDW'(1);
          done_cnt_d  = done_cnt_q + CNTW'(1);
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lat_data_q  <= '0;
      lat_mode_q  <= 1'b0;
      lat_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_mode_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lat_data_q  <= lat_data_d;
      lat_mode_q  <= lat_mode_d;
      lat_id_q    <= lat_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_mode_q  <= rsp_mode_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_mode  = rsp_mode_q;
  assign busy      = busy_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_code_conv_arbiter.sv
// Self-checking bench for code_conv_arbiter with a transaction-level reference model.
module tb_code_conv_arbiter;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned CNTW  = 2;
  localparam int unsigned IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_mode;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_mode;
  logic                  busy;
  logic [CNTW-1:0]       done_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int m_ptr = 0;
  int m_cnt = 0;

  code_conv_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_mode(req_mode), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_mode(rsp_mode), .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] ref_g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    for (int i = 0; i < int'(WIDTH); i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic logic [NREQ*WIDTH-1:0] slot(input int r, input logic [WIDTH-1:0] w);
    logic [NREQ*WIDTH-1:0] d;
    d = '0;
    d[r*WIDTH +: WIDTH] = w;
    return d;
  endfunction

  // One full request/response transaction; g = winner (-1 if none), got = delivered word
  task automatic xact(input logic [NREQ-1:0] v, input logic [NREQ-1:0] m,
                      input logic [NREQ*WIDTH-1:0] d, input int bp,
                      output int g, output logic [WIDTH-1:0] got);
    logic [WIDTH-1:0] din, exp;
    req_valid = v; req_mode = m; req_data = d;
    #1;
    g = -1;
    got = '0;
    for (int k = 0; k < int'(NREQ); k++)
      if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    if (g < 0) begin
      chk("idle_no_grant", 32'(req_ready), 0);
      chk("idle_busy", 32'(busy), 0);
      tick();
      return;
    end
    din = d[g*WIDTH +: WIDTH];
    exp = m[g] ? ref_g2b(din) : (din ^ (din >> 1));
    chk("grant", 32'(req_ready), 32'(1 << g));
    chk("idle_busy", 32'(busy), 0);
    tick();
    req_valid[g] = 1'b0;
    #1;
    chk("conv_ready", 32'(req_ready), 0);
    chk("conv_busy", 32'(busy), 1);
    chk("conv_valid", 32'(rsp_valid), 0);
    tick();
    chk("resp_valid", 32'(rsp_valid), 1);
    chk("resp_data", 32'(rsp_data), 32'(exp));
    chk("resp_id", 32'(rsp_id), 32'(g));
    chk("resp_mode", 32'(rsp_mode), 32'(m[g]));
    got = rsp_data;
    if (bp > 0) begin
      rsp_ready = 1'b0;
      repeat (bp) begin
        tick();
        chk("bp_valid", 32'(rsp_valid), 1);
        chk("bp_data", 32'(rsp_data), 32'(exp));
        chk("bp_id", 32'(rsp_id), 32'(g));
        chk("bp_ready", 32'(req_ready), 0);
        chk("bp_busy", 32'(busy), 1);
      end
      rsp_ready = 1'b1;
    end
    tick();
    m_ptr = (g + 1) % NREQ;
    m_cnt++;
    chk("post_valid", 32'(rsp_valid), 0);
    chk("post_busy", 32'(busy), 0);
    chk("done_cnt", 32'(done_cnt), 32'(m_cnt % (1 << CNTW)));
    chk("post_hold", 32'(rsp_data), 32'(exp));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; req_mode = '0; req_data = '0; rsp_ready = 1'b1;
    #1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    m_ptr = 0; m_cnt = 0;
  endtask

  initial begin
    int g;
    logic [WIDTH-1:0] got;
    logic [WIDTH-1:0] g2b_in  [4];
    logic [WIDTH-1:0] g2b_out [4];
    int rr_exp [6];
    int cnt_exp [5];

    g2b_in  = '{4'b1000, 4'b0011, 4'b1001, 4'b0000};
    g2b_out = '{4'b1111, 4'b0010, 4'b1110, 4'b0000};
    rr_exp  = '{0, 1, 2, 3, 0, 1};
    cnt_exp = '{1, 2, 3, 0, 1};

    rst_n = 1'b0; req_valid = '0; req_mode = '0; req_data = '0; rsp_ready = 1'b1;
    #2;
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(done_cnt), 0);
    chk("rst_data", 32'(rsp_data), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_mode", 32'(rsp_mode), 0);
    chk("rst_ready", 32'(req_ready), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single request: requester 2, binary 0101 -> Gray 0111
    xact(4'b0100, 4'b0000, slot(2, 4'b0101), 0, g, got);
    chk("single_id", 32'(g), 2);
    chk("single_data", 32'(got), 32'(4'b0111));
    chk("single_cnt", 32'(done_cnt), 1);

    // Gray -> binary sweep on requester 0
    for (int i = 0; i < 4; i++) begin
      xact(4'b0001, 4'b0001, slot(0, g2b_in[i]), 0, g, got);
      chk("g2b_sweep", 32'(got), 32'(g2b_out[i]));
    end

    // Full round trip: b2g then g2b returns the original code
    for (int i = 0; i < 16; i++) begin
      logic [WIDTH-1:0] gc;
      xact(4'b0010, 4'b0000, slot(1, WIDTH'(i)), 0, g, got);
      gc = got;
      xact(4'b0010, 4'b0010, slot(1, gc), 0, g, got);
      chk("roundtrip", 32'(got), 32'(i));
    end

    // Backpressure with other requests pending
    xact(4'b1111, 4'b0101, {4'hA, 4'h5, 4'hC, 4'h3}, 5, g, got);
    xact(4'b1111, 4'b0101, {4'hA, 4'h5, 4'hC, 4'h3}, 0, g, got);

    // Reset during CONV discards the in-flight request
    req_valid = '1; req_mode = '0; req_data = '1;
    tick();
    rst_n = 1'b0; req_valid = '0;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_cnt", 32'(done_cnt), 0);
    chk("midrst_data", 32'(rsp_data), 0);
    chk("midrst_id", 32'(rsp_id), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("midrst_no_rsp", 32'(rsp_valid), 0);
    m_ptr = 0; m_cnt = 0;

    // Round robin with all requesters asserting
    for (int i = 0; i < 6; i++) begin
      xact(4'b1111, 4'($urandom), 16'($urandom), 0, g, got);
      chk("rr_order", 32'(g), 32'(rr_exp[i]));
    end

    // Counter wrap at CNTW=2
    do_reset();
    for (int i = 0; i < 5; i++) begin
      xact(4'($urandom_range(1, 15)), 4'($urandom), 16'($urandom), 0, g, got);
      chk("cnt_wrap", 32'(done_cnt), 32'(cnt_exp[i]));
    end

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      xact(4'($urandom), 4'($urandom), 16'($urandom), int'($urandom_range(0, 3)), g, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
